// File: rtl/mem_access_stage.sv
// Load/store issue and write-back: ALU results after 1 cycle, memory ops 1 cycle after ack; ma_o_stall held while a request is open.
// Optional MEM_ACCESS_MISALIGN_EN: misaligned H/W accesses trap (no request, flush pulse) instead of being forced aligned.
module mem_access_stage #(
  parameter int DWIDTH  = 32,
  parameter int AWIDTH  = 5,
  parameter int MAWIDTH = 32
) (
  input  logic               ma_clk,
  input  logic               ma_rst,
  input  logic               ma_i_ce,
  input  logic               ma_i_stall,
  input  logic               ma_i_flush,
  input  logic               ma_i_load,
  input  logic               ma_i_store,
  input  logic [2:0]         ma_i_funct3,
  input  logic [MAWIDTH-1:0] ma_i_addr,
  input  logic [DWIDTH-1:0]  ma_i_wdata,
  input  logic [AWIDTH-1:0]  ma_i_rd_addr,
  input  logic [DWIDTH-1:0]  ma_i_rd_data,
  input  logic               ma_i_rd_we,
  output logic               ma_o_req,
  output logic               ma_o_we,
  output logic [MAWIDTH-1:0] ma_o_addr,
  output logic [DWIDTH-1:0]  ma_o_wdata,
  output logic [3:0]         ma_o_wsel,
  input  logic               ma_i_ack,
  input  logic [DWIDTH-1:0]  ma_i_rdata,
  output logic [AWIDTH-1:0]  ma_o_rd_addr,
  output logic [DWIDTH-1:0]  ma_o_rd_data,
  output logic               ma_o_rd_we,
  output logic               ma_o_ce,
  output logic               ma_o_stall,
  output logic               ma_o_flush
);
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  state_t             state_q;
  logic [MAWIDTH-1:0] req_addr_q;
  logic               req_we_q;
  logic [3:0]         req_wsel_q;
  logic [DWIDTH-1:0]  req_wdata_q;
  logic [1:0]         ld_off_q;
  logic [1:0]         ld_size_q;
  logic               ld_uns_q;
  logic [AWIDTH-1:0]  pend_rd_addr_q;
  logic               pend_rd_we_q;
  logic               kill_q;
  logic [AWIDTH-1:0]  rd_addr_q;
  logic [DWIDTH-1:0]  rd_data_q;
  logic               rd_we_q;
  logic               ce_q;
  logic               flush_q;

  logic               in_wait, mem_op, accept, misal, issue, done, kill;
  logic [1:0]         in_size, in_off, cur_off, cur_size;
  logic               cur_uns, cur_we, cur_rd_we;
  logic [AWIDTH-1:0]  cur_rd_addr;
  logic [3:0]         in_wsel;
  logic [DWIDTH-1:0]  in_wdata, ld_val;
  logic [MAWIDTH-1:0] in_addr;
  logic [7:0]         lane_b;
  logic [15:0]        lane_h;

  always_comb begin
    in_wait = (state_q == S_WAIT);
    mem_op  = ma_i_load | ma_i_store;
    accept  = ma_rst & ~in_wait & ma_i_ce & ~ma_i_stall & ~ma_i_flush;
    case (ma_i_funct3[1:0])
      2'b00:   in_size = SZ_B;
      2'b01:   in_size = SZ_H;
      default: in_size = SZ_W;
    endcase
`ifdef MEM_ACCESS_MISALIGN_EN
    misal = mem_op & (((in_size == SZ_H) & ma_i_addr[0]) |
                      ((in_size == SZ_W) & (ma_i_addr[1:0] != 2'b00)));
`else
    misal = 1'b0;
`endif
    issue = accept & mem_op & ~misal;
    // Lane offset already reflects natural alignment, so H/W ignore the low address bits
    case (in_size)
      SZ_B: begin
        in_off   = ma_i_addr[1:0];
        in_wsel  = 4'b0001 << in_off;
        in_wdata = {(DWIDTH/8){ma_i_wdata[7:0]}};
      end
      SZ_H: begin
        in_off   = {ma_i_addr[1], 1'b0};
        in_wsel  = 4'b0011 << in_off;
        in_wdata = {(DWIDTH/16){ma_i_wdata[15:0]}};
      end
      default: begin
        in_off   = 2'b00;
        in_wsel  = 4'b1111;
        in_wdata = ma_i_wdata;
      end
    endcase
    in_addr     = {ma_i_addr[MAWIDTH-1:2], 2'b00};
    cur_off     = in_wait ? ld_off_q       : in_off;
    cur_size    = in_wait ? ld_size_q      : in_size;
    cur_uns     = in_wait ? ld_uns_q       : ma_i_funct3[2];
    cur_we      = in_wait ? req_we_q       : ma_i_store;
    cur_rd_we   = in_wait ? pend_rd_we_q   : ma_i_rd_we;
    cur_rd_addr = in_wait ? pend_rd_addr_q : ma_i_rd_addr;
    kill        = in_wait & (kill_q | ma_i_flush);
    done        = (issue | in_wait) & ma_i_ack;
    lane_b      = ma_i_rdata[{cur_off, 3'b000} +: 8];
    lane_h      = ma_i_rdata[{cur_off[1], 4'b0000} +: 16];
    case (cur_size)
      SZ_B:    ld_val = cur_uns ? {{(DWIDTH-8){1'b0}}, lane_b} : {{(DWIDTH-8){lane_b[7]}}, lane_b};
      SZ_H:    ld_val = cur_uns ? {{(DWIDTH-16){1'b0}}, lane_h} : {{(DWIDTH-16){lane_h[15]}}, lane_h};
      default: ld_val = ma_i_rdata;
    endcase
  end

  always_ff @(posedge ma_clk or negedge ma_rst) begin
    if (!ma_rst) begin
      state_q        <= S_IDLE;
      req_addr_q     <= '0;
      req_we_q       <= 1'b0;
      req_wsel_q     <= '0;
      req_wdata_q    <= '0;
      ld_off_q       <= '0;
      ld_size_q      <= '0;
      ld_uns_q       <= 1'b0;
      pend_rd_addr_q <= '0;
      pend_rd_we_q   <= 1'b0;
      kill_q         <= 1'b0;
      rd_addr_q      <= '0;
      rd_data_q      <= '0;
      rd_we_q        <= 1'b0;
      ce_q           <= 1'b0;
      flush_q        <= 1'b0;
    end else begin
      ce_q    <= 1'b0;
      flush_q <= ma_i_flush | (accept & misal);
      if (done) begin
        state_q   <= S_IDLE;
        ce_q      <= ~kill;
        rd_addr_q <= cur_rd_addr;
        rd_we_q   <= ~kill & ~cur_we & cur_rd_we;
        rd_data_q <= cur_we ? '0 : ld_val;
      end else if (issue) begin
        state_q        <= S_WAIT;
        req_addr_q     <= in_addr;
        req_we_q       <= ma_i_store;
        req_wsel_q     <= in_wsel;
        req_wdata_q    <= in_wdata;
        ld_off_q       <= in_off;
        ld_size_q      <= in_size;
        ld_uns_q       <= ma_i_funct3[2];
        pend_rd_addr_q <= ma_i_rd_addr;
        pend_rd_we_q   <= ma_i_rd_we;
        kill_q         <= 1'b0;
      end else if (in_wait) begin
        if (ma_i_flush) kill_q <= 1'b1;
      end else if (accept) begin
        // ALU result, or a trapped misaligned access that retires without writing
        ce_q      <= 1'b1;
        rd_addr_q <= ma_i_rd_addr;
        rd_we_q   <= ma_i_rd_we & ~misal;
        rd_data_q <= ma_i_rd_data;
      end
    end
  end

  assign ma_o_req     = issue | in_wait;
  assign ma_o_we      = in_wait ? req_we_q    : ma_i_store;
  assign ma_o_addr    = in_wait ? req_addr_q  : in_addr;
  assign ma_o_wdata   = in_wait ? req_wdata_q : in_wdata;
  assign ma_o_wsel    = in_wait ? req_wsel_q  : in_wsel;
  assign ma_o_stall   = ma_i_stall | in_wait | (issue & ~ma_i_ack);
  assign ma_o_rd_addr = rd_addr_q;
  assign ma_o_rd_data = rd_data_q;
  assign ma_o_rd_we   = rd_we_q;
  assign ma_o_ce      = ce_q;
  assign ma_o_flush   = flush_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: driver pushes expected requests/write-backs, responder and monitor check.
module tb_mem_access_stage;
  localparam int DW = 32, AW = 5, MAW = 32;

  logic ma_clk = 1'b0, ma_rst = 1'b0;
  logic ma_i_ce = 0, ma_i_stall = 0, ma_i_flush = 0, ma_i_load = 0, ma_i_store = 0;
  logic [2:0] ma_i_funct3 = 0;
  logic [MAW-1:0] ma_i_addr = 0;
  logic [DW-1:0] ma_i_wdata = 0, ma_i_rd_data = 0, ma_i_rdata = 0;
  logic [AW-1:0] ma_i_rd_addr = 0;
  logic ma_i_rd_we = 0, ma_i_ack = 0;
  logic ma_o_req, ma_o_we, ma_o_rd_we, ma_o_ce, ma_o_stall, ma_o_flush;
  logic [MAW-1:0] ma_o_addr;
  logic [DW-1:0] ma_o_wdata, ma_o_rd_data;
  logic [3:0] ma_o_wsel;
  logic [AW-1:0] ma_o_rd_addr;

  mem_access_stage #(.DWIDTH(DW), .AWIDTH(AW), .MAWIDTH(MAW)) dut (
    .ma_clk(ma_clk), .ma_rst(ma_rst), .ma_i_ce(ma_i_ce), .ma_i_stall(ma_i_stall),
    .ma_i_flush(ma_i_flush), .ma_i_load(ma_i_load), .ma_i_store(ma_i_store),
    .ma_i_funct3(ma_i_funct3), .ma_i_addr(ma_i_addr), .ma_i_wdata(ma_i_wdata),
    .ma_i_rd_addr(ma_i_rd_addr), .ma_i_rd_data(ma_i_rd_data), .ma_i_rd_we(ma_i_rd_we),
    .ma_o_req(ma_o_req), .ma_o_we(ma_o_we), .ma_o_addr(ma_o_addr), .ma_o_wdata(ma_o_wdata),
    .ma_o_wsel(ma_o_wsel), .ma_i_ack(ma_i_ack), .ma_i_rdata(ma_i_rdata),
    .ma_o_rd_addr(ma_o_rd_addr), .ma_o_rd_data(ma_o_rd_data), .ma_o_rd_we(ma_o_rd_we),
    .ma_o_ce(ma_o_ce), .ma_o_stall(ma_o_stall), .ma_o_flush(ma_o_flush)
  );

  always #5 ma_clk = ~ma_clk;

  typedef struct {logic [AW-1:0] rd; logic [DW-1:0] data; logic we; bit chk_data; int due;} wb_t;
  typedef struct {logic [MAW-1:0] addr; logic we; logic [3:0] wsel; logic [DW-1:0] wdata; int lat; logic [DW-1:0] rdata;} rq_t;
  wb_t wbq[$];
  rq_t rqq[$];

  int errors = 0, checks = 0, cyc = 0;
  bit mis_flag = 0, late_ack = 0;

  always @(posedge ma_clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: byte/half extraction by plain arithmetic on the address offset
  function automatic logic [DW-1:0] ref_load(input logic [2:0] f3, input logic [1:0] a, input logic [DW-1:0] rd);
    int unsigned b, h;
    b = (rd >> (8 * a)) & 32'hFF;
    h = (rd >> (16 * (a / 2))) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'b001:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] ref_wsel(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'(1 << a);
      2'b01:   return 4'(3 << (2 * (a / 2)));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [DW-1:0] ref_wdata(input logic [2:0] f3, input logic [DW-1:0] d);
    case (f3[1:0])
      2'b00:   return (d & 32'hFF) * 32'h0101_0101;
      2'b01:   return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic bit ref_misal(input logic [2:0] f3, input logic [1:0] a);
`ifdef MEM_ACCESS_MISALIGN_EN
    return (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
`else
    return (f3 == 3'b111) && (a == 2'b11) && 1'b0;
`endif
  endfunction

  task automatic step();
    @(posedge ma_clk);
    #1;
  endtask

  task automatic clear_in();
    ma_i_ce = 0; ma_i_load = 0; ma_i_store = 0; ma_i_flush = 0; ma_i_stall = 0;
  endtask

  task automatic do_alu(input logic [AW-1:0] rd, input logic [DW-1:0] d, input logic we,
                        input int stall_c, input bit drop);
    ma_i_ce = 1; ma_i_load = 0; ma_i_store = 0;
    ma_i_rd_addr = rd; ma_i_rd_data = d; ma_i_rd_we = we; ma_i_addr = $urandom;
    if (drop) begin
      ma_i_flush = 1; step(); clear_in(); return;
    end
    ma_i_stall = 1; repeat (stall_c) step(); ma_i_stall = 0;
    wbq.push_back('{rd, d, we, 1'b1, cyc + 1});
    step(); clear_in();
  endtask

  task automatic do_mem(input logic [2:0] f3, input logic [MAW-1:0] a, input logic [DW-1:0] d,
                        input bit ld, input logic [AW-1:0] rd, input logic we, input int lat,
                        input logic [DW-1:0] rdata, input bit fl, input int stall_c, input bit drop);
    ma_i_ce = 1; ma_i_load = ld; ma_i_store = !ld; ma_i_funct3 = f3; ma_i_addr = a;
    ma_i_wdata = d; ma_i_rd_addr = rd; ma_i_rd_we = we; ma_i_rd_data = $urandom;
    if (drop) begin
      ma_i_flush = 1; step(); clear_in(); return;
    end
    ma_i_stall = 1; repeat (stall_c) step(); ma_i_stall = 0;
    if (ref_misal(f3, a[1:0])) begin
      mis_flag = 1;
      wbq.push_back('{rd, '0, 1'b0, 1'b0, cyc + 1});
      step(); mis_flag = 0; clear_in(); return;
    end
    rqq.push_back('{a & ~32'h3, !ld, ref_wsel(f3, a[1:0]), ref_wdata(f3, d), lat, rdata});
    if (!fl) wbq.push_back('{rd, ld ? ref_load(f3, a[1:0], rdata) : '0, ld ? we : 1'b0, ld, cyc + lat + 1});
    step(); clear_in();
    for (int k = 1; k <= lat; k++) begin
      ma_i_flush = fl && (k == 1);
      step();
    end
    ma_i_flush = 0;
  endtask

  // Memory responder
  rq_t cur;
  bit active = 0;
  int cnt = 0;
  always @(negedge ma_clk) begin
    bit first;
    if (ma_o_req) begin
      if (!active) begin
        if (rqq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req actual addr=%0h required no request", ma_o_addr);
          cur = '{ma_o_addr, ma_o_we, ma_o_wsel, ma_o_wdata, 0, '0};
        end else cur = rqq.pop_front();
        active = 1; cnt = 0;
      end
      chk("req_addr", ma_o_addr, cur.addr);
      chk("req_we", ma_o_we, cur.we);
      if (cur.we) begin
        chk("req_wsel", ma_o_wsel, cur.wsel);
        chk("req_wdata", ma_o_wdata, cur.wdata);
      end
      first = (cnt == 0);
      ma_i_ack = (cnt == cur.lat);
      ma_i_rdata = ma_i_ack ? cur.rdata : $urandom;
      if (ma_i_ack) active = 0;
      cnt++;
      #1 chk("stall_mem", ma_o_stall, !(first && ma_i_ack));
    end else begin
      active = 0;
      ma_i_ack = late_ack;
      ma_i_rdata = $urandom;
    end
  end

  // Write-back monitor
  bit pf = 0, pm = 0;
  always @(negedge ma_clk) begin
    if (ma_rst) begin
      if (ma_o_ce) begin
        if (wbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ce actual ce=1 rd=%0d required ce=0", ma_o_rd_addr);
        end else begin
          wb_t e;
          e = wbq.pop_front();
          chk("wb_cycle", cyc, e.due);
          chk("wb_rd_addr", ma_o_rd_addr, e.rd);
          chk("wb_rd_we", ma_o_rd_we, e.we);
          if (e.chk_data) chk("wb_rd_data", ma_o_rd_data, e.data);
        end
      end else if (wbq.size() != 0 && wbq[0].due <= cyc) begin
        void'(wbq.pop_front());
        chk("missing_ce", 1'b0, 1'b1);
      end
      if (!ma_o_req) chk("stall_idle", ma_o_stall, ma_i_stall);
      chk("o_flush", ma_o_flush, pf | pm);
      pf = ma_i_flush; pm = mis_flag;
    end else begin
      pf = 0; pm = 0;
    end
  end

  logic [2:0] ldf [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  initial begin
    #1;
    chk("rst_req", ma_o_req, 0);
    chk("rst_ce", ma_o_ce, 0);
    chk("rst_rd", {ma_o_rd_addr, ma_o_rd_data, ma_o_rd_we}, 0);
    chk("rst_flush", ma_o_flush, 0);
    step(); step(); ma_rst = 1; step();

    do_mem(3'b010, 32'h104, 32'hDEAD_BEEF, 0, 5'd3, 1, 3, '0, 0, 0, 0);
    do_mem(3'b000, 32'h203, '0, 1, 5'd4, 1, 0, 32'h80FF_FF00, 0, 0, 0);
    do_mem(3'b100, 32'h203, '0, 1, 5'd5, 1, 0, 32'h80FF_FF00, 0, 0, 0);
    do_mem(3'b001, 32'h202, '0, 1, 5'd6, 1, 1, 32'h1234_5678, 0, 0, 0);
    do_mem(3'b001, 32'h202, 32'h0000_ABCD, 0, 5'd6, 1, 2, '0, 0, 0, 0);
    do_alu(5'd7, 32'h55, 1, 0, 0);
    do_mem(3'b010, 32'h300, '0, 1, 5'd8, 1, 2, 32'h1111_2222, 1, 0, 0);
    do_mem(3'b010, 32'h101, '0, 1, 5'd9, 1, 1, 32'hCAFE_F00D, 0, 0, 0);
    do_alu(5'd10, 32'h99, 1, 2, 0);
    do_alu(5'd11, 32'h77, 1, 0, 1);
    repeat (2) step();

    // Reset in the middle of an open request, followed by a stray ack
    ma_i_ce = 1; ma_i_load = 1; ma_i_funct3 = 3'b010; ma_i_addr = 32'h400; ma_i_rd_addr = 5'd12; ma_i_rd_we = 1;
    rqq.push_back('{32'h400, 1'b0, 4'hF, '0, 50, '0});
    step(); clear_in(); step();
    #2 ma_rst = 0;
    #1;
    chk("midrst_req", ma_o_req, 0);
    chk("midrst_ce", ma_o_ce, 0);
    chk("midrst_rd", {ma_o_rd_addr, ma_o_rd_data, ma_o_rd_we}, 0);
    chk("midrst_flush", ma_o_flush, 0);
    step(); ma_rst = 1; late_ack = 1; step(); step(); late_ack = 0; step();

    for (int i = 0; i < 200; i++) begin
      int kind, lat, stall_c;
      bit drop, fl;
      kind = $urandom_range(0, 2);
      drop = ($urandom_range(0, 9) == 0);
      stall_c = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      lat = $urandom_range(0, 3);
      fl = (lat > 0) && ($urandom_range(0, 4) == 0);
      case (kind)
        0: do_alu(5'($urandom), $urandom, 1'($urandom), stall_c, drop);
        1: do_mem(ldf[$urandom_range(0, 4)], $urandom, $urandom, 1, 5'($urandom), 1'($urandom),
                  lat, $urandom, fl, stall_c, drop);
        default: do_mem(3'($urandom_range(0, 2)), $urandom, $urandom, 0, 5'($urandom), 1'($urandom),
                        lat, $urandom, fl, stall_c, drop);
      endcase
      if ($urandom_range(0, 3) == 0) step();
    end

    repeat (5) step();
    chk("wb_queue_drained", wbq.size(), 0);
    chk("req_queue_drained", rqq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, data and register width.
REQ-002 SHALL have parameter AWIDTH, default 5, register-file address width.
REQ-003 SHALL have parameter MAWIDTH, default 32, data-memory byte-address width.
REQ-004 SHALL have one clock and an asynchronous active-low reset: ma_clk input 1, clock.
REQ-005 ma_rst input 1, asynchronous active-low reset.
REQ-006 ma_i_ce input 1, upstream (execute) result valid.
REQ-007 ma_i_stall input 1, downstream stall request.
REQ-008 ma_i_flush input 1, kill the current instruction.
REQ-009 ma_i_load input 1, instruction is a load.
REQ-010 ma_i_store input 1, instruction is a store.
REQ-011 ma_i_funct3 input 3, access size and sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-012 ma_i_addr input MAWIDTH, effective byte address from the ALU.
REQ-013 ma_i_wdata input DWIDTH, store data (rs2).
REQ-014 ma_i_rd_addr input AWIDTH, destination register.
REQ-015 ma_i_rd_data input DWIDTH, ALU result for non-load instructions.
REQ-016 ma_i_rd_we input 1, destination write enable.
REQ-017 ma_o_req output 1, data-memory request.
REQ-018 ma_o_we output 1, data-memory write (1) or read (0).
REQ-019 ma_o_addr output MAWIDTH, word-aligned memory address (bits [1:0] = 0).
REQ-020 ma_o_wdata output DWIDTH, lane-replicated store data.
REQ-021 ma_o_wsel output 4, byte-lane write strobes.
REQ-022 ma_i_ack input 1, memory completion; read data valid in the same cycle.
REQ-023 ma_i_rdata input DWIDTH, memory read word.
REQ-024 ma_o_rd_addr / ma_o_rd_data / ma_o_rd_we outputs AWIDTH/DWIDTH/1, registered write-back triple; rd_data is the formatted load value or the ALU result.
REQ-025 ma_o_ce output 1, ma_o_rd_* valid, one-cycle pulse per instruction.
REQ-026 ma_o_stall / ma_o_flush outputs 1/1, stall and flush to upstream stages.

Function
REQ-027 SHALL use FSM IDLE/WAIT; IDLE with ce & ~stall & ~flush & (load|store) -> drive req, we=store, aligned addr, wsel, wdata combinationally and go WAIT; held stable until ack.
REQ-028 Non-memory instruction (ce, neither load nor store) SHALL appear on ma_o_rd_* with ma_o_ce=1 exactly one cycle later.
REQ-029 In WAIT, ack SHALL register the result (ce=1 next cycle, rd_we=store?0:ma_i_rd_we) and return to IDLE; ack in the issue cycle completes with latency 1.
REQ-030 ma_o_stall SHALL equal ma_i_stall | (state==WAIT) | (issue cycle & ~ack).
REQ-031 Load formatting: B/H pick lane by addr[1:0]/addr[1]; B, H sign-extend; BU, HU zero-extend; W passes through.
REQ-032 Store: SB wsel=0001<<addr[1:0], data byte replicated x4; SH wsel=0011<<{addr[1],0}, half replicated x2; SW wsel=1111.
REQ-033 ma_i_stall high in IDLE SHALL hold all registered outputs and suppress new requests; ce output SHALL be 0 while held.
REQ-034 Flush in IDLE SHALL drop the instruction (no req, ce=0); flush in WAIT SHALL keep req until ack, then discard (ce=0, rd_we=0); ma_o_flush mirrors ma_i_flush registered.

Reset
REQ-035 ma_rst low SHALL immediately set state IDLE, ma_o_req=0, and every registered output to 0, including mid-transaction; a late ack after reset SHALL be ignored.

Configuration
REQ-036 Macro MEM_ACCESS_MISALIGN_EN defined: a misaligned H/W access SHALL issue no request, produce ce=1 with rd_we=0, and pulse ma_o_flush for one cycle; undefined: addr low bits are forced to natural alignment and the access proceeds.

Verification
REQ-037 SW addr 0x104 data 0xDEADBEEF, ack after 3 cycles -> req 4 cycles, wsel 1111, addr 0x104, stall high until ack, ce=1 with rd_we=0 next cycle.
REQ-038 LB addr 0x203, rdata 0x80FF_FF00, ack same cycle -> rd_data 0xFFFFFF80, ce pulse 1 cycle later; LBU -> 0x00000080.
REQ-039 LH addr 0x202, rdata 0x1234_5678 -> rd_data 0x00001234; SH addr 0x202 data 0xABCD -> wsel 1100, wdata 0xABCDABCD.
REQ-040 ADD result 0x55 rd=7, no memory op -> req stays 0, rd_addr 7, rd_data 0x55, ce=1 one cycle later.
REQ-041 Load issued, flush asserted while in WAIT, ack 2 cycles later -> req held until ack, ce=0, rd_we=0.
REQ-042 Reset low during WAIT -> req=0 immediately, all outputs 0; with MEM_ACCESS_MISALIGN_EN, LW addr 0x101 -> no req, flush pulse, rd_we=0.
